// File: rtl/adf4030_align_sequencer.sv
// BSYNC alignment sequencer: direction switch, generator gating, lock wait,
// alignment qualification and trigger-channel arming with bounded retry/timeout.
module adf4030_align_sequencer #(
  parameter int unsigned CHANNEL_COUNT  = 1,
  parameter int unsigned GUARD_CYCLES   = 16,
  parameter int unsigned SETTLE_EVENTS  = 8,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     cfg_direction,
  input  logic [CHANNEL_COUNT-1:0] cfg_ch_en,
  input  logic                     bsync_ready,
  input  logic                     bsync_event,
  input  logic                     bsync_captured,
  input  logic                     bsync_alignment_error,
  output logic                     direction,
  output logic                     disable_internal_bsync,
  output logic [CHANNEL_COUNT-1:0] trig_channel_en,
  output logic                     busy,
  output logic                     done,
  output logic                     fail,
  output logic [3:0]               retry_cnt,
  output logic [2:0]               seq_state
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);
  localparam int unsigned EW = $clog2(SETTLE_EVENTS + 1);

  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
  localparam logic [EW-1:0] EVENT_MAX  = EW'(SETTLE_EVENTS);
  localparam logic [3:0]    RETRY_MAX  = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SWITCH     = 3'd1,
    S_WAIT_READY = 3'd2,
    S_SETTLE     = 3'd3,
    S_RETRY      = 3'd4,
    S_ARMED      = 3'd5,
    S_FAIL       = 3'd6
  } state_t;

  state_t                   r_state;
  logic                     r_direction;
  logic                     r_disable;
  logic [CHANNEL_COUNT-1:0] r_trig;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_fail;
  logic [3:0]               r_retry;
  logic [TW-1:0]            r_timer;
  logic [GW-1:0]            r_guard;
  logic [EW-1:0]            r_evcnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_direction <= 1'b0;
      r_disable   <= 1'b1;
      r_trig      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_retry     <= '0;
      r_timer     <= '0;
      r_guard     <= '0;
      r_evcnt     <= '0;
    end else begin
      // Enables track the registered state, so they lag every state change by one clk.
      r_trig <= (r_state == S_ARMED) ? cfg_ch_en : '0;
      if (abort) begin
        r_state   <= S_IDLE;
        r_done    <= 1'b0;
        r_busy    <= 1'b0;
        r_disable <= 1'b1;
      end else if (start) begin
        r_state     <= S_SWITCH;
        r_retry     <= '0;
        r_done      <= 1'b0;
        r_fail      <= 1'b0;
        r_busy      <= 1'b1;
        r_disable   <= 1'b1;
        r_direction <= cfg_direction;
        r_guard     <= '0;
      end else begin
        case (r_state)
          S_IDLE: ;
          S_SWITCH: begin
            if (r_guard == GUARD_LAST) begin
              r_state   <= S_WAIT_READY;
              r_disable <= 1'b0;
              r_timer   <= '0;
            end else begin
              r_guard <= r_guard + 1'b1;
            end
          end
          S_WAIT_READY: begin
            if (bsync_ready) begin
              r_state <= S_SETTLE;
              r_timer <= '0;
              r_evcnt <= '0;
            end else if (r_timer == TIMER_MAX) begin
              r_state <= S_RETRY;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          S_SETTLE: begin
            if (r_timer != TIMER_MAX) r_timer <= r_timer + 1'b1;
            if (bsync_alignment_error || !bsync_ready) begin
              r_state <= S_RETRY;
            end else if (r_evcnt == EVENT_MAX) begin
              if (!r_direction || bsync_captured) begin
                r_state <= S_ARMED;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_RETRY;
              end
            end else if (bsync_event) begin
              r_evcnt <= r_evcnt + 1'b1;
            end else if (r_timer == TIMER_MAX) begin
              r_state <= S_RETRY;
            end
          end
          S_RETRY: begin
            if (r_retry == RETRY_MAX) begin
              r_state   <= S_FAIL;
              r_fail    <= 1'b1;
              r_busy    <= 1'b0;
              r_disable <= 1'b1;
            end else begin
              r_state     <= S_SWITCH;
              r_retry     <= r_retry + 1'b1;
              r_busy      <= 1'b1;
              r_disable   <= 1'b1;
              r_direction <= cfg_direction;
              r_guard     <= '0;
            end
          end
          S_ARMED: begin
            if (bsync_alignment_error || !bsync_ready) begin
              r_state <= S_RETRY;
              r_done  <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
          S_FAIL: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign direction              = r_direction;
  assign disable_internal_bsync = r_disable;
  assign trig_channel_en        = r_trig;
  assign busy                   = r_busy;
  assign done                   = r_done;
  assign fail                   = r_fail;
  assign retry_cnt              = r_retry;
  assign seq_state              = r_state;

endmodule

// File: tb/tb_adf4030_align_sequencer.sv
// Directed self-checking bench for adf4030_align_sequencer.
module tb_adf4030_align_sequencer;

  localparam int unsigned CH = 2;
  localparam logic [2:0] S_IDLE = 3'd0, S_SWITCH = 3'd1, S_WAIT = 3'd2, S_SETTLE = 3'd3,
                         S_RETRY = 3'd4, S_ARMED = 3'd5, S_FAIL = 3'd6;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          cfg_direction = 1'b0;
  logic [CH-1:0] cfg_ch_en = '0;
  logic          bsync_ready = 1'b0;
  logic          bsync_event = 1'b0;
  logic          bsync_captured = 1'b0;
  logic          bsync_alignment_error = 1'b0;
  logic          direction, disable_internal_bsync, busy, done, fail;
  logic [CH-1:0] trig_channel_en;
  logic [3:0]    retry_cnt;
  logic [2:0]    seq_state;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  adf4030_align_sequencer #(
    .CHANNEL_COUNT (CH),
    .GUARD_CYCLES  (16),
    .SETTLE_EVENTS (8),
    .MAX_RETRY     (3),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cfg_direction(cfg_direction), .cfg_ch_en(cfg_ch_en),
    .bsync_ready(bsync_ready), .bsync_event(bsync_event),
    .bsync_captured(bsync_captured), .bsync_alignment_error(bsync_alignment_error),
    .direction(direction), .disable_internal_bsync(disable_internal_bsync),
    .trig_channel_en(trig_channel_en), .busy(busy), .done(done), .fail(fail),
    .retry_cnt(retry_cnt), .seq_state(seq_state)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task send_events(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      bsync_event = 1'b1;
      tick();
      bsync_event = 1'b0;
      tick();
    end
  endtask

  task wait_state(input logic [2:0] s, input int unsigned limit, output bit ok);
    for (int unsigned i = 0; i < limit; i++) begin
      if (seq_state != s) tick();
    end
    ok = (seq_state == s);
  endtask

  task test_reset;
    tick();
    tick();
    n_total++; if (seq_state !== S_IDLE) $display("FAIL reset_state: got %0d want 0", seq_state); else n_pass++;
    n_total++; if ({direction, disable_internal_bsync, busy, done, fail} !== 5'b01000)
      $display("FAIL reset_flags: got %b want 01000", {direction, disable_internal_bsync, busy, done, fail}); else n_pass++;
    n_total++; if (trig_channel_en !== 2'b00) $display("FAIL reset_trig: got %b want 00", trig_channel_en); else n_pass++;
    n_total++; if (retry_cnt !== 4'd0) $display("FAIL reset_retry: got %0d want 0", retry_cnt); else n_pass++;
    rstn = 1'b1;
    tick();
    tick();
    n_total++; if (seq_state !== S_IDLE) $display("FAIL idle_hold: got %0d want 0", seq_state); else n_pass++;
  endtask

  task test_normal;
    cfg_direction = 1'b0;
    cfg_ch_en = 2'b10;
    bsync_ready = 1'b0;
    pulse_start();
    n_total++; if ({seq_state, busy, disable_internal_bsync} !== {S_SWITCH, 2'b11})
      $display("FAIL switch_entry: got %0d/%b/%b want 1/1/1", seq_state, busy, disable_internal_bsync); else n_pass++;
    repeat (15) tick();
    n_total++; if (seq_state !== S_SWITCH) $display("FAIL guard_hold: got %0d want 1", seq_state); else n_pass++;
    tick();
    n_total++; if ({seq_state, disable_internal_bsync} !== {S_WAIT, 1'b0})
      $display("FAIL guard_end: got %0d/%b want 2/0", seq_state, disable_internal_bsync); else n_pass++;
    repeat (20) tick();
    n_total++; if (seq_state !== S_WAIT) $display("FAIL wait_ready_hold: got %0d want 2", seq_state); else n_pass++;
    bsync_ready = 1'b1;
    tick();
    n_total++; if (seq_state !== S_SETTLE) $display("FAIL settle_entry: got %0d want 3", seq_state); else n_pass++;
    send_events(8);
    n_total++; if ({seq_state, done, busy, retry_cnt} !== {S_ARMED, 2'b10, 4'd0})
      $display("FAIL armed: got st=%0d done=%b busy=%b retry=%0d want 5/1/0/0", seq_state, done, busy, retry_cnt); else n_pass++;
    n_total++; if (trig_channel_en !== 2'b00) $display("FAIL trig_lag: got %b want 00", trig_channel_en); else n_pass++;
    tick();
    n_total++; if (trig_channel_en !== 2'b10) $display("FAIL trig_on: got %b want 10", trig_channel_en); else n_pass++;
    cfg_ch_en = 2'b11;
    tick();
    n_total++; if (trig_channel_en !== 2'b11) $display("FAIL trig_live: got %b want 11", trig_channel_en); else n_pass++;
  endtask

  task test_capture_fail;
    bit ok;
    cfg_direction = 1'b1;
    bsync_captured = 1'b0;
    bsync_ready = 1'b1;
    pulse_start();
    for (int unsigned a = 0; a < 4; a++) begin
      wait_state(S_SETTLE, 40, ok);
      n_total++; if (!ok) $display("FAIL cap_reach_settle: attempt %0d got st=%0d want 3", a, seq_state); else n_pass++;
      n_total++; if (direction !== 1'b1) $display("FAIL cap_direction: got %b want 1", direction); else n_pass++;
      send_events(8);
      n_total++; if (seq_state !== S_RETRY) $display("FAIL cap_retry: attempt %0d got %0d want 4", a, seq_state); else n_pass++;
      tick();
      if (a < 3) begin
        n_total++; if ({seq_state, retry_cnt} !== {S_SWITCH, 4'(a + 1)})
          $display("FAIL cap_reswitch: got st=%0d retry=%0d want 1/%0d", seq_state, retry_cnt, a + 1); else n_pass++;
      end else begin
        n_total++; if ({seq_state, fail, busy, disable_internal_bsync, retry_cnt} !== {S_FAIL, 3'b101, 4'd3})
          $display("FAIL cap_fail: got st=%0d fail=%b busy=%b dis=%b retry=%0d want 6/1/0/1/3",
                   seq_state, fail, busy, disable_internal_bsync, retry_cnt); else n_pass++;
      end
    end
    tick();
    n_total++; if (trig_channel_en !== 2'b00) $display("FAIL cap_trig: got %b want 00", trig_channel_en); else n_pass++;
  endtask

  task test_align_error_retry;
    bit ok;
    cfg_direction = 1'b0;
    bsync_ready = 1'b1;
    pulse_start();
    n_total++; if ({fail, retry_cnt} !== 5'd0) $display("FAIL restart_clear: got fail=%b retry=%0d want 0/0", fail, retry_cnt); else n_pass++;
    wait_state(S_SETTLE, 40, ok);
    n_total++; if (!ok) $display("FAIL err_reach_settle: got %0d want 3", seq_state); else n_pass++;
    send_events(4);
    bsync_event = 1'b1;
    bsync_alignment_error = 1'b1;
    tick();
    bsync_event = 1'b0;
    bsync_alignment_error = 1'b0;
    n_total++; if ({seq_state, retry_cnt} !== {S_RETRY, 4'd0})
      $display("FAIL err_retry: got st=%0d retry=%0d want 4/0", seq_state, retry_cnt); else n_pass++;
    tick();
    n_total++; if ({seq_state, retry_cnt} !== {S_SWITCH, 4'd1})
      $display("FAIL err_reswitch: got st=%0d retry=%0d want 1/1", seq_state, retry_cnt); else n_pass++;
    wait_state(S_SETTLE, 40, ok);
    send_events(7);
    n_total++; if (seq_state !== S_SETTLE) $display("FAIL err_7_events: got %0d want 3", seq_state); else n_pass++;
    send_events(1);
    n_total++; if ({seq_state, retry_cnt, done} !== {S_ARMED, 4'd1, 1'b1})
      $display("FAIL err_armed: got st=%0d retry=%0d done=%b want 5/1/1", seq_state, retry_cnt, done); else n_pass++;
  endtask

  task test_timeout;
    bit ok;
    int unsigned cnt;
    bsync_ready = 1'b0;
    cfg_direction = 1'b0;
    pulse_start();
    for (int unsigned a = 0; a < 4; a++) begin
      wait_state(S_WAIT, 40, ok);
      n_total++; if (!ok) $display("FAIL to_reach_wait: attempt %0d got %0d want 2", a, seq_state); else n_pass++;
      cnt = 0;
      while (seq_state == S_WAIT && cnt < 300) begin
        cnt++;
        tick();
      end
      n_total++; if (cnt !== 101 || seq_state !== S_RETRY)
        $display("FAIL to_wait_len: attempt %0d got %0d clks st=%0d want 101 clks st=4", a, cnt, seq_state); else n_pass++;
      tick();
      if (a < 3) begin
        n_total++; if ({seq_state, retry_cnt} !== {S_SWITCH, 4'(a + 1)})
          $display("FAIL to_reswitch: got st=%0d retry=%0d want 1/%0d", seq_state, retry_cnt, a + 1); else n_pass++;
      end else begin
        n_total++; if ({seq_state, fail, retry_cnt} !== {S_FAIL, 1'b1, 4'd3})
          $display("FAIL to_fail: got st=%0d fail=%b retry=%0d want 6/1/3", seq_state, fail, retry_cnt); else n_pass++;
      end
    end
  endtask

  task test_armed_error_abort;
    bit ok;
    cfg_direction = 1'b1;
    bsync_captured = 1'b1;
    bsync_ready = 1'b1;
    cfg_ch_en = 2'b01;
    pulse_start();
    wait_state(S_SETTLE, 40, ok);
    send_events(8);
    n_total++; if (seq_state !== S_ARMED) $display("FAIL cap_armed: got %0d want 5", seq_state); else n_pass++;
    tick();
    n_total++; if (trig_channel_en !== 2'b01) $display("FAIL ae_trig_on: got %b want 01", trig_channel_en); else n_pass++;
    bsync_alignment_error = 1'b1;
    tick();
    bsync_alignment_error = 1'b0;
    n_total++; if ({seq_state, done, trig_channel_en} !== {S_RETRY, 1'b0, 2'b01})
      $display("FAIL ae_retry: got st=%0d done=%b trig=%b want 4/0/01", seq_state, done, trig_channel_en); else n_pass++;
    tick();
    n_total++; if ({seq_state, retry_cnt, trig_channel_en} !== {S_SWITCH, 4'd1, 2'b00})
      $display("FAIL ae_trig_off: got st=%0d retry=%0d trig=%b want 1/1/00", seq_state, retry_cnt, trig_channel_en); else n_pass++;
    wait_state(S_SETTLE, 40, ok);
    send_events(8);
    tick();
    n_total++; if ({seq_state, trig_channel_en} !== {S_ARMED, 2'b01})
      $display("FAIL ae_rearm: got st=%0d trig=%b want 5/01", seq_state, trig_channel_en); else n_pass++;
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    n_total++; if ({seq_state, done, busy, disable_internal_bsync, direction} !== {S_IDLE, 4'b0011})
      $display("FAIL abort_idle: got st=%0d done=%b busy=%b dis=%b dir=%b want 0/0/0/1/1",
               seq_state, done, busy, disable_internal_bsync, direction); else n_pass++;
    tick();
    n_total++; if ({seq_state, trig_channel_en} !== {S_IDLE, 2'b00})
      $display("FAIL abort_trig: got st=%0d trig=%b want 0/00", seq_state, trig_channel_en); else n_pass++;
  endtask

  task test_reset_mid;
    bit ok;
    cfg_direction = 1'b1;
    cfg_ch_en = 2'b11;
    pulse_start();
    wait_state(S_SETTLE, 40, ok);
    send_events(3);
    rstn = 1'b0;
    #2;
    n_total++; if ({seq_state, direction, disable_internal_bsync, busy, done, fail, retry_cnt, trig_channel_en}
                   !== {S_IDLE, 5'b01000, 4'd0, 2'b00})
      $display("FAIL async_reset: got st=%0d dir=%b dis=%b busy=%b retry=%0d trig=%b",
               seq_state, direction, disable_internal_bsync, busy, retry_cnt, trig_channel_en); else n_pass++;
    tick();
    rstn = 1'b1;
    tick();
    n_total++; if (seq_state !== S_IDLE) $display("FAIL post_reset_idle: got %0d want 0", seq_state); else n_pass++;
    pulse_start();
    wait_state(S_SETTLE, 40, ok);
    send_events(8);
    tick();
    n_total++; if ({seq_state, retry_cnt, trig_channel_en} !== {S_ARMED, 4'd0, 2'b11})
      $display("FAIL post_reset_arm: got st=%0d retry=%0d trig=%b want 5/0/11", seq_state, retry_cnt, trig_channel_en); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_capture_fail();
    test_align_error_retry();
    test_timeout();
    test_armed_error_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
